// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: frame states, line levels
// and a counter-width helper used by the serializer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Bit-counter width able to hold DATA_WIDTH-1 (never narrower than 1 bit)
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Data-bit serializer: holds the frame's data byte and emits it LSB-first.
// ser_data is always the next bit to place on the line. The first shift
// happens on the start-bit cycle, which hands bit 0 to the line register;
// from then on bit_cnt indexes the data bit currently on the line, so
// ser_done marks the last data bit.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  primed;

  // Load the byte on acceptance, then shift right once per emitted bit
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg   <= '0;
      bit_cnt <= '0;
      primed  <= 1'b0;
    end else if (load) begin
      shreg   <= load_data;
      bit_cnt <= '0;
      primed  <= 1'b0;
    end else if (shift) begin
      shreg  <= {1'b0, shreg[DATA_WIDTH-1:1]};
      primed <= 1'b1;
      if (primed) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign ser_data = shreg[0];
  assign ser_done = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framing engine. One serial bit per CLK cycle:
// start, DATA_WIDTH data bits LSB-first, optional parity, stop.
// The state register names the bit currently on TX_OUT; each transition
// loads TX_OUT with the level of the bit that comes next.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line high, BUSY low, accepting DATA_VALID
// START  | start bit (0) on the line
// DATA   | data bit bit_cnt on the line
// PARITY | parity bit (par_bit captured on entry) on the line
// STOP   | stop bit (1) on the line, BUSY still high, no acceptance
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  tx_state_e state;
  logic      par_en_q;
  logic      load;
  logic      shift;
  logic      ser_data;
  logic      ser_done;

  // Capture a new byte only while idle; shift on start and all but the last data bit
  assign load  = (state == IDLE) && DATA_VALID;
  assign shift = (state == START) || ((state == DATA) && !ser_done);

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .CLK       (CLK),
    .RST       (RST),
    .load      (load),
    .load_data (P_DATA),
    .shift     (shift),
    .ser_data  (ser_data),
    .ser_done  (ser_done)
  );

  // Frame sequencer with registered line level and busy flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      TX_OUT   <= IDLE_LEVEL;
      BUSY     <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (DATA_VALID) begin
            state    <= START;
            TX_OUT   <= START_BIT;
            BUSY     <= 1'b1;
            par_en_q <= PAR_EN;
          end else begin
            TX_OUT <= IDLE_LEVEL;
            BUSY   <= 1'b0;
          end
        end
        START: begin
          state  <= DATA;
          TX_OUT <= ser_data;
        end
        DATA: begin
          if (!ser_done) begin
            TX_OUT <= ser_data;
          end else if (par_en_q) begin
            state  <= PARITY;
            TX_OUT <= par_bit;
          end else begin
            state  <= STOP;
            TX_OUT <= STOP_BIT;
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= STOP_BIT;
        end
        STOP: begin
          state  <= IDLE;
          TX_OUT <= IDLE_LEVEL;
          BUSY   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= IDLE_LEVEL;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a frame-list reference model queues the expected
// {BUSY,TX_OUT} per cycle at each acceptance and a monitor compares every
// cycle; directed steps add fixed waveform and boundary checks.
module tb_uart_tx_frame;

  localparam int DW = 8;

  typedef struct packed {
    logic busy;
    logic tx;
  } obs_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          par_bit = 1'b0;
  logic          TX_OUT;
  logic          BUSY;

  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  obs_t exp_q[$];
  obs_t cur_exp = 2'b01;

  always #5 CLK = ~CLK;

  uart_tx_frame #(
    .DATA_WIDTH (DW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .par_bit    (par_bit),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  // Reference model: on acceptance push the whole frame, then pop one entry per cycle
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      exp_q.delete();
      cur_exp <= 2'b01;
    end else if (exp_q.size() > 0) begin
      cur_exp <= exp_q.pop_front();
    end else if (!cur_exp.busy && DATA_VALID) begin
      cur_exp <= 2'b10;
      for (int i = 0; i < DW; i++) exp_q.push_back({1'b1, P_DATA[i]});
      if (PAR_EN) exp_q.push_back({1'b1, par_bit});
      exp_q.push_back(2'b11);
    end else begin
      cur_exp <= 2'b01;
    end
  end

  // Cycle monitor, sampled on the inactive edge
  always @(negedge CLK) begin
    if (mon_en) begin
      checks++;
      assert ({BUSY, TX_OUT} === cur_exp)
      else begin
        failures++;
        $error("FAIL line_monitor t=%0t got busy/tx=%b expected=%b", $time, {BUSY, TX_OUT}, cur_exp);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (BUSY !== 1'b0 && k < 40) begin
      @(negedge CLK);
      k++;
    end
    chk("wait_idle_timeout", {31'd0, BUSY}, 32'd0);
  endtask

  // Send one byte from idle and record n line bits starting at cycle N+1
  task automatic send_capture(input string tag, input logic [DW-1:0] d, input logic pe,
                              input logic pb, input int n, input logic [15:0] exp_bits);
    logic [15:0] bits = '0;
    int          bcnt = 0;
    @(negedge CLK);
    P_DATA = d;
    PAR_EN = pe;
    par_bit = pb;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    P_DATA = ~d;
    PAR_EN = ~pe;
    for (int i = 0; i < n; i++) begin
      bits = {bits[14:0], TX_OUT};
      if (BUSY) bcnt++;
      @(negedge CLK);
    end
    chk({tag, "_bits"}, {16'd0, bits}, {16'd0, exp_bits});
    chk({tag, "_busy_cycles"}, bcnt, n);
    chk({tag, "_idle_after"}, {30'd0, BUSY, TX_OUT}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_tx", {31'd0, TX_OUT}, 32'd1);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    RST = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge CLK);

    send_capture("a5_even", 8'hA5, 1'b1, 1'b0, 11, 16'b00000_01010010101);
    send_capture("x01_odd", 8'h01, 1'b1, 1'b0, 11, 16'b00000_01000000001);
    send_capture("x03_odd", 8'h03, 1'b1, 1'b1, 11, 16'b00000_01100000011);
    send_capture("xff_nopar", 8'hFF, 1'b0, 1'b0, 10, 16'b000000_0111111111);

    // DATA_VALID held high, data and parity enable changing every cycle
    @(negedge CLK);
    par_bit = 1'b1;
    DATA_VALID = 1'b1;
    for (int i = 0; i < 60; i++) begin
      P_DATA = DW'($urandom);
      PAR_EN = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    DATA_VALID = 1'b0;
    wait_idle();

    // DATA_VALID pulsed mid-frame with other data: must be ignored
    @(negedge CLK);
    P_DATA = 8'h3C;
    PAR_EN = 1'b0;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    P_DATA = 8'hC3;
    PAR_EN = 1'b1;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    wait_idle();
    repeat (5) @(negedge CLK);
    chk("no_follow_frame", {31'd0, BUSY}, 32'd0);

    // Asynchronous reset during data bit 3
    @(negedge CLK);
    P_DATA = 8'hA5;
    PAR_EN = 1'b1;
    par_bit = 1'b0;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    chk("pre_rst_bit3", {30'd0, BUSY, TX_OUT}, 32'd2);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst_tx", {31'd0, TX_OUT}, 32'd1);
    chk("async_rst_busy", {31'd0, BUSY}, 32'd0);
    @(negedge CLK);
    P_DATA = 8'h5A;
    PAR_EN = 1'b0;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    chk("held_in_rst", {30'd0, BUSY, TX_OUT}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    chk("accept_after_rst", {30'd0, BUSY, TX_OUT}, 32'd2);
    wait_idle();
    repeat (3) @(negedge CLK);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
